// File: rtl/if_stage.sv
// Instruction-fetch stage: one-outstanding-request imem front end feeding the
// IF/ID register, with a one-entry skid buffer to absorb responses during stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [4:0]  if_id_rs1,
  output logic [4:0]  if_id_rs2
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        skid_vld, skid_vld_nxt, skid_load;
  logic [31:0] skid_pc, skid_instr;
  logic        ifid_vld_nxt;
  logic [31:0] ifid_pc_nxt, ifid_instr_nxt;
  logic [4:0]  ifid_rs1_nxt, ifid_rs2_nxt;
  logic        accept, rsp_fresh;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] inc_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // No new request may go out while the skid buffer still holds an instruction.
  assign imem_req_valid = rst_n && (state == S_REQ) && !skid_vld;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_fresh      = (state == S_WAIT) && imem_rsp_valid;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_vld_nxt   = skid_vld;
    skid_load      = 1'b0;
    ifid_vld_nxt   = if_id_valid;
    ifid_pc_nxt    = if_id_pc;
    ifid_instr_nxt = if_id_instr;

    unique case (state)
      S_REQ:   if (accept) state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
      S_WAIT:  begin
        if (redirect_valid) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          pc_nxt    = inc_pc(pc);
        end
      end
      S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_nxt       = align_pc(redirect_pc);
      skid_vld_nxt = 1'b0;
      ifid_vld_nxt = 1'b0;
    end else if (!stall) begin
      if (skid_vld) begin
        ifid_vld_nxt   = 1'b1;
        ifid_pc_nxt    = skid_pc;
        ifid_instr_nxt = skid_instr;
        skid_vld_nxt   = 1'b0;
      end else if (rsp_fresh) begin
        ifid_vld_nxt   = 1'b1;
        ifid_pc_nxt    = pc;
        ifid_instr_nxt = imem_rsp_data;
      end else begin
        ifid_vld_nxt   = 1'b0;
      end
    end else if (rsp_fresh) begin
      skid_vld_nxt = 1'b1;
      skid_load    = 1'b1;
    end

    ifid_rs1_nxt = ifid_vld_nxt ? ifid_instr_nxt[19:15] : 5'd0;
    ifid_rs2_nxt = ifid_vld_nxt ? ifid_instr_nxt[24:20] : 5'd0;
  end

  // IF -> ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      skid_vld    <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_rs1   <= 5'd0;
      if_id_rs2   <= 5'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      skid_vld    <= skid_vld_nxt;
      if_id_valid <= ifid_vld_nxt;
      if_id_pc    <= ifid_pc_nxt;
      if_id_instr <= ifid_instr_nxt;
      if_id_rs1   <= ifid_rs1_nxt;
      if_id_rs2   <= ifid_rs2_nxt;
    end
  end

  // Skid payload is qualified by skid_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_pc    <= pc;
      skid_instr <= imem_rsp_data;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port stall  input  1  hazard-unit stall; hold IF/ID contents and PC.
REQ-005 SHALL provide port redirect_valid  input  1  taken branch/jump resolved in ID; flush and refetch.
REQ-006 SHALL provide port redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007 SHALL provide port imem_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL provide port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 SHALL provide port imem_addr  output  32  request address; word aligned.
REQ-010 SHALL provide port imem_rsp_valid  input  1  response data valid; arrives 1 or more cycles after acceptance.
REQ-011 SHALL provide port imem_rsp_data  input  32  fetched instruction.
REQ-012 SHALL provide ports if_id_valid (1), if_id_pc (32), if_id_instr (32), all outputs: the IF/ID pipeline register.
REQ-013 SHALL provide ports if_id_rs1 and if_id_rs2, outputs, 5 bits each: if_id_instr[19:15] and [24:20], zero when if_id_valid=0.

Function
REQ-014 SHALL keep at most one outstanding imem request.
REQ-015 SHALL implement FSM states REQ, WAIT and DRAIN.
- REQ: imem_req_valid=1, imem_addr=pc; on valid&&ready go to WAIT.
- WAIT: await imem_rsp_valid.
- DRAIN: discard the pending response, then go to REQ.
REQ-016 SHALL count a request as accepted only when imem_req_valid && imem_req_ready are both high in the same cycle; imem_addr SHALL stay stable while valid is high and ready is low.
REQ-017 SHALL, on a response in WAIT with stall=0 and the skid buffer empty, load if_id_valid=1, if_id_pc=pc and if_id_instr=rsp_data, set pc=pc+4 and return to REQ.
REQ-018 SHALL, on a response in WAIT with stall=1, capture {pc, rsp_data} in a one-entry skid buffer, set pc=pc+4 and hold IF/ID unchanged.
REQ-019 SHALL NOT issue a new request (state REQ, imem_req_valid forced 0) while the skid buffer is full.
REQ-020 SHALL, in the first cycle with stall=0 and the skid buffer full, move the buffer into IF/ID (valid=1) and empty the buffer.
REQ-021 SHALL, with stall=0 and no new instruction available, load if_id_valid=0 (bubble); if_id_pc and if_id_instr are don't-care.
REQ-022 SHALL hold all IF/ID fields unchanged while stall=1 and redirect_valid=0.
REQ-023 SHALL, on redirect_valid=1, do all of the following regardless of stall:
- set if_id_valid=0 next cycle;
- empty the skid buffer;
- set pc={redirect_pc[31:2],2'b00}.
REQ-024 SHALL, on a redirect that occurs in WAIT with no response that cycle, or that coincides with acceptance in REQ, enter DRAIN; a response arriving in the same cycle as the redirect SHALL be discarded, with the next state REQ.
REQ-025 SHALL, in DRAIN, drop exactly one response, keep imem_req_valid=0, and accept a further redirect by updating pc only.
REQ-026 SHALL, on redirect while in REQ without acceptance, stay in REQ with the new pc next cycle.
REQ-027 SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 SHALL drive all outputs from registers, except imem_req_valid and imem_addr, which are decoded from state, pc and buffer occupancy.

Reset
REQ-029 SHALL, while rst_n=0, immediately force the following without waiting for clk:
- state=REQ, pc=RESET_PC;
- skid buffer empty;
- if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013 (NOP);
- imem_req_valid=0.
REQ-030 SHALL assert imem_req_valid with imem_addr=RESET_PC in the first cycle after rst_n rises.
REQ-031 SHALL abandon an outstanding request on reset and SHALL NOT drop a later response because of it; the memory is reset together with this block.

Verification
REQ-032 Reset, then zero-wait memory (ready=1, response next cycle) -> if_id_pc sequence 0x0, 0x4, 0x8, with if_id_valid=1 every other cycle.
REQ-033 stall=1 for 3 cycles while a response at pc 0x8 arrives -> IF/ID holds 0x4, no request is issued while the buffer is full, and the first unstalled cycle loads pc 0x8.
REQ-034 redirect_valid=1, redirect_pc=0x103 while in WAIT -> if_id_valid=0, the late response is dropped, and the next request address is 0x100.
REQ-035 imem_req_ready=0 for 4 cycles -> imem_addr stable and imem_req_valid held at 1 throughout.
REQ-036 pc=0xFFFF_FFFC fetched -> next imem_addr is 0x0000_0000.
REQ-037 rst_n pulsed low mid-WAIT -> outputs reach their reset values asynchronously, and the fetch restarts at RESET_PC.
